// File: rtl/mem_stage.sv
// Memory pipeline stage: holds one entry from execute, waits for load data when
// needed, and hands the result to write-back under valid/allowin flow control.
module mem_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         ws_allowin,
  output logic         ms_allowin,
  input  logic         es_to_ms_valid,
  input  logic [134:0] es_to_ms_bus,
  output logic         ms_to_ws_valid,
  output logic [133:0] ms_to_ws_bus,
  input  logic [63:0]  data_sram_rdata,
  input  logic         data_sram_rvalid,
  output logic [4:0]   ms_fwd_dest,
  output logic         ms_fwd_block,
  output logic [7:0]   ms_wait_cnt,
  output logic [1:0]   ms_state_o
);

  // Handshake: a transfer happens on a rising edge where the sender's valid and
  // the receiver's allowin are both 1; valid payloads stay stable until taken.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           ms_valid_q, ms_valid_d;
  logic [134:0]   ms_bus_q, ms_bus_d;
  logic [63:0]    rdata_buf_q, rdata_buf_d;
  logic [7:0]     wait_cnt_q, wait_cnt_d;

  logic           ms_ready_go;
  logic           allowin_int;
  logic           accept;
  logic [63:0]    final_result;

  always_comb begin
    ms_ready_go = 1'b0;
    case (state_q)
      S_WAIT:  ms_ready_go = data_sram_rvalid;
      S_DONE:  ms_ready_go = 1'b1;
      default: ms_ready_go = 1'b0;
    endcase

    allowin_int = !ms_valid_q || (ms_ready_go && ws_allowin);
    accept      = es_to_ms_valid && allowin_int;

    state_d     = state_q;
    ms_valid_d  = ms_valid_q;
    ms_bus_d    = ms_bus_q;
    rdata_buf_d = rdata_buf_q;
    wait_cnt_d  = wait_cnt_q;

    if (allowin_int) begin
      ms_valid_d = es_to_ms_valid;
      if (es_to_ms_valid) begin
        ms_bus_d = es_to_ms_bus;
        state_d  = es_to_ms_bus[134] ? S_WAIT : S_DONE;
      end else begin
        state_d  = S_IDLE;
      end
    end else if (state_q == S_WAIT && data_sram_rvalid) begin
      // Data arrived but write-back is stalled: park it in the buffer.
      state_d = S_DONE;
    end

    if (state_q == S_WAIT && data_sram_rvalid) begin
      rdata_buf_d = data_sram_rdata;
    end

    if (accept && es_to_ms_bus[134]) begin
      wait_cnt_d = 8'd0;
    end else if (state_q == S_WAIT && !data_sram_rvalid && wait_cnt_q != 8'hFF) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end

    if (!ms_bus_q[134]) begin
      final_result = ms_bus_q[127:64];
    end else if (state_q == S_WAIT) begin
      final_result = data_sram_rdata;
    end else begin
      final_result = rdata_buf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ms_valid_q  <= 1'b0;
      rdata_buf_q <= 64'd0;
      wait_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      ms_valid_q  <= ms_valid_d;
      rdata_buf_q <= rdata_buf_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  // Payload is only meaningful while ms_valid_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    ms_bus_q <= ms_bus_d;
  end

  assign ms_allowin     = !reset || allowin_int;
  assign ms_to_ws_valid = reset && ms_valid_q && ms_ready_go;
  assign ms_to_ws_bus   = {ms_bus_q[133], ms_bus_q[132:128], final_result, ms_bus_q[63:0]};
  assign ms_fwd_dest    = (reset && ms_valid_q && ms_bus_q[133]) ? ms_bus_q[132:128] : 5'd0;
  assign ms_fwd_block   = reset && (state_q == S_WAIT) && !data_sram_rvalid;
  assign ms_wait_cnt    = wait_cnt_q;
  assign ms_state_o     = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a table of per-cycle input/expected records plus
// hand-written sequences for long waits, wait-counter saturation and stray rvalid.
module tb_mem_stage;

  logic         clk;
  logic         reset;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [134:0] es_to_ms_bus;
  logic         ms_to_ws_valid;
  logic [133:0] ms_to_ws_bus;
  logic [63:0]  data_sram_rdata;
  logic         data_sram_rvalid;
  logic [4:0]   ms_fwd_dest;
  logic         ms_fwd_block;
  logic [7:0]   ms_wait_cnt;
  logic [1:0]   ms_state_o;

  mem_stage dut (
    .clk              (clk),
    .reset            (reset),
    .ws_allowin       (ws_allowin),
    .ms_allowin       (ms_allowin),
    .es_to_ms_valid   (es_to_ms_valid),
    .es_to_ms_bus     (es_to_ms_bus),
    .ms_to_ws_valid   (ms_to_ws_valid),
    .ms_to_ws_bus     (ms_to_ws_bus),
    .data_sram_rdata  (data_sram_rdata),
    .data_sram_rvalid (data_sram_rvalid),
    .ms_fwd_dest      (ms_fwd_dest),
    .ms_fwd_block     (ms_fwd_block),
    .ms_wait_cnt      (ms_wait_cnt),
    .ms_state_o       (ms_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, esv, ld, we;
    logic [4:0]  dest;
    logic [63:0] alu, pc;
    logic        ws, rv;
    logic [63:0] rdata;
    logic        e_allowin, e_v, e_we;
    logic [63:0] e_res, e_pc;
    logic [4:0]  e_dest, e_fwd;
    logic        e_blk;
    logic [7:0]  e_cnt;
    logic [1:0]  e_st;
  } vec_t;

  vec_t vq[$];
  vec_t cur;
  int   n_vec = 0;
  int   n_err = 0;

  // driver tasks
  task automatic drive(input logic rst_n, esv, ld, we, input logic [4:0] dest,
                       input logic [63:0] alu, pc, input logic ws, rv,
                       input logic [63:0] rdata);
    reset            = rst_n;
    es_to_ms_valid   = esv;
    es_to_ms_bus     = {ld, we, dest, alu, pc};
    ws_allowin       = ws;
    data_sram_rvalid = rv;
    data_sram_rdata  = rdata;
  endtask

  task automatic in_(input logic rst_n, esv, ld, we, input logic [4:0] dest,
                     input logic [63:0] alu, pc, input logic ws, rv,
                     input logic [63:0] rdata);
    cur.rst_n = rst_n; cur.esv = esv; cur.ld = ld; cur.we = we; cur.dest = dest;
    cur.alu = alu; cur.pc = pc; cur.ws = ws; cur.rv = rv; cur.rdata = rdata;
  endtask

  task automatic ex_(input logic allowin, v, we, input logic [63:0] res, pc,
                     input logic [4:0] dest, fwd, input logic blk,
                     input logic [7:0] cnt, input logic [1:0] st);
    cur.e_allowin = allowin; cur.e_v = v; cur.e_we = we; cur.e_res = res;
    cur.e_pc = pc; cur.e_dest = dest; cur.e_fwd = fwd; cur.e_blk = blk;
    cur.e_cnt = cnt; cur.e_st = st;
    vq.push_back(cur);
  endtask

  task automatic ex_idle(input logic [7:0] cnt);
    ex_(1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 5'd0, 1'b0, cnt, 2'd0);
  endtask

  task automatic idle_in(input logic ws);
    in_(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, ws, 1'b0, 64'd0);
  endtask

  // scoreboard compare
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0);
    repeat (2) @(negedge clk);

    // reset state
    in_(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0); ex_idle(8'd0);

    // single non-load
    in_(1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 64'h1234, 64'h1000, 1'b1, 1'b0, 64'd0); ex_idle(8'd0);
    idle_in(1'b1); ex_(1'b1, 1'b1, 1'b1, 64'h1234, 64'h1000, 5'd5, 5'd5, 1'b0, 8'd0, 2'd2);
    idle_in(1'b1); ex_idle(8'd0);

    // load, data three cycles after accept
    in_(1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 64'h2000, 64'h1004, 1'b1, 1'b0, 64'd0); ex_idle(8'd0);
    idle_in(1'b1); ex_(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 5'd7, 1'b1, 8'd0, 2'd1);
    idle_in(1'b1); ex_(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 5'd7, 1'b1, 8'd1, 2'd1);
    in_(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b1, 1'b1, 64'hDEADBEEF00000001);
    ex_(1'b1, 1'b1, 1'b1, 64'hDEADBEEF00000001, 64'h1004, 5'd7, 5'd7, 1'b0, 8'd2, 2'd1);
    idle_in(1'b1); ex_idle(8'd2);

    // load data while write-back stalled 4 cycles; pending entry held off, then back-to-back
    in_(1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 64'h3000, 64'h1008, 1'b1, 1'b0, 64'd0); ex_idle(8'd2);
    in_(1'b1, 1'b1, 1'b0, 1'b1, 5'd31, 64'hBAD, 64'hBAD0, 1'b0, 1'b1, 64'h0123456789ABCDEF);
    ex_(1'b0, 1'b1, 1'b1, 64'h0123456789ABCDEF, 64'h1008, 5'd3, 5'd3, 1'b0, 8'd0, 2'd1);
    in_(1'b1, 1'b1, 1'b0, 1'b1, 5'd31, 64'hBAD, 64'hBAD0, 1'b0, 1'b0, 64'd0);
    ex_(1'b0, 1'b1, 1'b1, 64'h0123456789ABCDEF, 64'h1008, 5'd3, 5'd3, 1'b0, 8'd0, 2'd2);
    in_(1'b1, 1'b1, 1'b0, 1'b1, 5'd31, 64'hBAD, 64'hBAD0, 1'b0, 1'b1, 64'hFF);
    ex_(1'b0, 1'b1, 1'b1, 64'h0123456789ABCDEF, 64'h1008, 5'd3, 5'd3, 1'b0, 8'd0, 2'd2);
    in_(1'b1, 1'b1, 1'b0, 1'b1, 5'd31, 64'hBAD, 64'hBAD0, 1'b0, 1'b0, 64'd0);
    ex_(1'b0, 1'b1, 1'b1, 64'h0123456789ABCDEF, 64'h1008, 5'd3, 5'd3, 1'b0, 8'd0, 2'd2);
    in_(1'b1, 1'b1, 1'b0, 1'b1, 5'd31, 64'hBAD, 64'hBAD0, 1'b1, 1'b0, 64'd0);
    ex_(1'b1, 1'b1, 1'b1, 64'h0123456789ABCDEF, 64'h1008, 5'd3, 5'd3, 1'b0, 8'd0, 2'd2);
    idle_in(1'b1); ex_(1'b1, 1'b1, 1'b1, 64'hBAD, 64'hBAD0, 5'd31, 5'd31, 1'b0, 8'd0, 2'd2);
    idle_in(1'b1); ex_idle(8'd0);

    // five back-to-back non-loads
    for (int k = 0; k < 5; k++) begin
      in_(1'b1, 1'b1, 1'b0, 1'b1, 5'(k + 1), 64'h100 + 64'(k), 64'h80000000 + 64'(4 * k),
          1'b1, 1'b0, 64'd0);
      if (k == 0) ex_idle(8'd0);
      else ex_(1'b1, 1'b1, 1'b1, 64'h100 + 64'(k - 1), 64'h80000000 + 64'(4 * (k - 1)),
               5'(k), 5'(k), 1'b0, 8'd0, 2'd2);
    end
    idle_in(1'b1); ex_(1'b1, 1'b1, 1'b1, 64'h104, 64'h80000010, 5'd5, 5'd5, 1'b0, 8'd0, 2'd2);
    idle_in(1'b1); ex_idle(8'd0);

    // gr_we=0 suppresses forwarding
    in_(1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 64'h55, 64'h2000, 1'b1, 1'b0, 64'd0); ex_idle(8'd0);
    idle_in(1'b1); ex_(1'b1, 1'b1, 1'b0, 64'h55, 64'h2000, 5'd9, 5'd0, 1'b0, 8'd0, 2'd2);
    idle_in(1'b1); ex_idle(8'd0);

    // reset during WAIT, then stray rvalid
    in_(1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 64'd0, 64'h3000, 1'b1, 1'b0, 64'd0); ex_idle(8'd0);
    in_(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0);
    ex_(1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 5'd0, 1'b0, 8'd0, 2'd1);
    in_(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b1, 1'b1, 64'hAA); ex_idle(8'd0);
    idle_in(1'b1); ex_idle(8'd0);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].rst_n, vq[i].esv, vq[i].ld, vq[i].we, vq[i].dest, vq[i].alu, vq[i].pc,
            vq[i].ws, vq[i].rv, vq[i].rdata);
      #1;
      n_vec++;
      chk($sformatf("v%0d allowin", i), 64'(ms_allowin), 64'(vq[i].e_allowin));
      chk($sformatf("v%0d valid", i), 64'(ms_to_ws_valid), 64'(vq[i].e_v));
      chk($sformatf("v%0d fwd_dest", i), 64'(ms_fwd_dest), 64'(vq[i].e_fwd));
      chk($sformatf("v%0d fwd_block", i), 64'(ms_fwd_block), 64'(vq[i].e_blk));
      chk($sformatf("v%0d wait_cnt", i), 64'(ms_wait_cnt), 64'(vq[i].e_cnt));
      chk($sformatf("v%0d state", i), 64'(ms_state_o), 64'(vq[i].e_st));
      if (vq[i].e_v) begin
        chk($sformatf("v%0d gr_we", i), 64'(ms_to_ws_bus[133]), 64'(vq[i].e_we));
        chk($sformatf("v%0d dest", i), 64'(ms_to_ws_bus[132:128]), 64'(vq[i].e_dest));
        chk($sformatf("v%0d result", i), ms_to_ws_bus[127:64], vq[i].e_res);
        chk($sformatf("v%0d pc", i), ms_to_ws_bus[63:0], vq[i].e_pc);
      end
    end

    // long wait: counter saturates, then handoff with a new entry accepted alongside
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd6, 64'h4000, 64'h5000, 1'b1, 1'b0, 64'd0);
    #1; n_vec++;
    chk("sat accept state", 64'(ms_state_o), 64'd0);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0);
    end
    #1; n_vec++;
    chk("sat wait_cnt", 64'(ms_wait_cnt), 64'd255);
    chk("sat block", 64'(ms_fwd_block), 64'd1);
    chk("sat valid", 64'(ms_to_ws_valid), 64'd0);
    chk("sat allowin", 64'(ms_allowin), 64'd0);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd10, 64'h77, 64'h6000, 1'b1, 1'b1, 64'hCAFE);
    #1; n_vec++;
    chk("sat handoff valid", 64'(ms_to_ws_valid), 64'd1);
    chk("sat handoff result", ms_to_ws_bus[127:64], 64'hCAFE);
    chk("sat handoff dest", 64'(ms_to_ws_bus[132:128]), 64'd6);
    chk("sat handoff allowin", 64'(ms_allowin), 64'd1);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0);
    #1; n_vec++;
    chk("b2b state", 64'(ms_state_o), 64'd2);
    chk("b2b valid", 64'(ms_to_ws_valid), 64'd1);
    chk("b2b result", ms_to_ws_bus[127:64], 64'h77);
    chk("b2b dest", 64'(ms_to_ws_bus[132:128]), 64'd10);
    chk("b2b wait_cnt", 64'(ms_wait_cnt), 64'd255);

    // stray rvalid while idle leaves everything alone
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b1, 1'b1, 64'hFF);
    #1; n_vec++;
    chk("stray state", 64'(ms_state_o), 64'd0);
    chk("stray valid", 64'(ms_to_ws_valid), 64'd0);
    chk("stray block", 64'(ms_fwd_block), 64'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0);
    #1; n_vec++;
    chk("stray state after", 64'(ms_state_o), 64'd0);
    chk("stray rdata_buf", dut.rdata_buf_q, 64'hCAFE);
    chk("stray wait_cnt", 64'(ms_wait_cnt), 64'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset), sampled on the clk rising edge.
REQ-003 SHALL have port ws_allowin, input, 1 bit: the write-back stage can accept this cycle.
REQ-004 SHALL have port ms_allowin, output, 1 bit: this stage accepts es_to_ms_bus this cycle.
REQ-005 SHALL have port es_to_ms_valid, input, 1 bit: upstream bus valid.
REQ-006 SHALL have port es_to_ms_bus, input, 135 bits: {res_from_mem[134], gr_we[133], dest[132:128], alu_result[127:64], pc[63:0]}.
REQ-007 SHALL have port ms_to_ws_valid, output, 1 bit: downstream bus valid.
REQ-008 SHALL have port ms_to_ws_bus, output, 134 bits: {gr_we[133], dest[132:128], final_result[127:64], pc[63:0]}.
REQ-009 SHALL have port data_sram_rdata, input, 64 bits: load data, meaningful only when data_sram_rvalid=1.
REQ-010 SHALL have port data_sram_rvalid, input, 1 bit: one-cycle pulse per load response, arriving 1 or more cycles after the load address was issued.
REQ-011 SHALL have port ms_fwd_dest, output, 5 bits: the dest to forward to decode; 0 when ms_valid=0 or gr_we=0.
REQ-012 SHALL have port ms_fwd_block, output, 1 bit: 1 while a load sits in WAIT; decode must stall on a dest match.
REQ-013 SHALL have port ms_wait_cnt, output, 8 bits: number of cycles the current/last load spent in WAIT.

Function
REQ-014 SHALL register es_to_ms_bus into ms_bus_r when es_to_ms_valid && ms_allowin.
REQ-015 SHALL update ms_valid <= es_to_ms_valid whenever ms_allowin=1.
REQ-016 SHALL drive ms_allowin = !ms_valid || (ms_ready_go && ws_allowin), combinationally.
REQ-017 SHALL drive ms_to_ws_valid = ms_valid && ms_ready_go.
REQ-018 SHALL implement a 3-state FSM: IDLE (empty), WAIT (load without data), DONE (result held).
REQ-019 SHALL move to WAIT on accepting an entry with res_from_mem=1, and to DONE on accepting an entry with res_from_mem=0.
REQ-020 SHALL, in WAIT with rvalid=1, set ms_ready_go=1 and forward data_sram_rdata combinationally as final_result; it SHALL also capture rdata into rdata_buf.
REQ-021 SHALL, in WAIT with rvalid=1 and ws_allowin=0, move to DONE and hold rdata_buf as final_result until ws_allowin=1.
REQ-022 SHALL use final_result = alu_result for non-loads, and rdata_buf in DONE for loads.
REQ-023 SHALL, on handoff (ms_to_ws_valid && ws_allowin), go to the state selected by any simultaneously accepted new entry, otherwise to IDLE.
REQ-024 SHALL support back-to-back: handoff and accept in the same cycle, with no bubble for non-loads.
REQ-025 SHALL ignore data_sram_rvalid in IDLE and DONE; no state change, rdata_buf unchanged.
REQ-026 SHALL hold ms_ready_go=0 in WAIT until rvalid, with no upper bound on the wait.
REQ-027 SHALL clear ms_wait_cnt to 0 on entry to WAIT, increment it each WAIT cycle without rvalid, and saturate it at 255.
REQ-028 SHALL assert ms_fwd_block = (state==WAIT) && !rvalid.
REQ-029 SHALL keep the ms_to_ws_bus fields stable while ms_to_ws_valid=1 and ws_allowin=0.

Reset
REQ-030 SHALL, while reset=0, force state=IDLE, ms_valid=0, rdata_buf=0, ms_wait_cnt=0; outputs: ms_to_ws_valid=0, ms_allowin=1, ms_fwd_block=0, ms_fwd_dest=0.
REQ-031 SHALL, if reset is asserted mid-WAIT, abandon the load; an rvalid arriving after reset release in IDLE is ignored per REQ-025.
REQ-032 SHALL leave ms_bus_r unreset; it is don't-care while ms_valid=0.

Verification
REQ-033 SHALL cover this case: non-load with alu_result=0x1234, dest=5, gr_we=1, ws_allowin=1 -> next cycle ms_to_ws_valid=1, final_result=0x1234, dest=5.
REQ-034 SHALL cover this case: load, rvalid 3 cycles after accept with rdata=0xDEADBEEF00000001 -> ms_to_ws_valid low 2 cycles, then high with that data; ms_wait_cnt=2; ms_fwd_block high 2 cycles.
REQ-035 SHALL cover this case: load, rvalid while ws_allowin=0 for 4 cycles -> state DONE, final_result stable at captured rdata, ms_allowin=0, handoff on the first cycle ws_allowin=1.
REQ-036 SHALL cover this case: five back-to-back non-loads, pc 0x80000000..0x80000010, ws_allowin=1 -> five consecutive valid outputs, no bubbles, in order.
REQ-037 SHALL cover this case: reset=0 for one cycle during WAIT, then a stray rvalid -> ms_to_ws_valid stays 0 and state stays IDLE.
REQ-038 SHALL cover this case: rvalid pulse in IDLE with rdata=0xFF -> rdata_buf and outputs unchanged.
